// File: rtl/hni_req_admit.sv
// RXREQ admission stage: same-cycle accept/retry at s0, RetryAck and
// PCrdGrant queuing toward TXRSP, tracker entry accounting.
module hni_req_admit #(
   parameter int TRK_ENTRIES  = 16,
   parameter int RETRYQ_DEPTH = 8,
   parameter int PCRDQ_DEPTH  = 16,
   parameter int LL_CRD_COUNT = 8,
   parameter int REQ_W        = 64,
   parameter int SRC_W        = 11,
   parameter int TXN_W        = 12,
   parameter int SRCID_LSB    = 15,
   parameter int TXNID_LSB    = 26,
   parameter int AR_BIT       = 56
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rxreq_valid_s0,
   input  logic [REQ_W-1:0] rxreqflit_s0,
   output logic             rxreq_retry_enable_s0,
   input  logic             trk_free_s0,
   output logic             qos_req_valid_s1,
   output logic [REQ_W-1:0] qos_reqflit_s1,
   output logic             qos_retryack_valid,
   output logic [SRC_W-1:0] qos_retryack_srcid,
   output logic [TXN_W-1:0] qos_retryack_txnid,
   input  logic             txrsp_retryack_won_s1,
   output logic             qos_pcrdgnt_valid,
   output logic [SRC_W-1:0] qos_pcrdgnt_srcid,
   input  logic             txrsp_pcrdgnt_won_s1,
   output logic             qos_pcrd_err
);

   localparam int CW  = $clog2(TRK_ENTRIES + 1);
   localparam int RAW = (RETRYQ_DEPTH > 1) ? $clog2(RETRYQ_DEPTH) : 1;
   localparam int PAW = (PCRDQ_DEPTH > 1) ? $clog2(PCRDQ_DEPTH) : 1;
   localparam int RCW = $clog2(RETRYQ_DEPTH + 1);
   localparam int PCW = $clog2(PCRDQ_DEPTH + 1);
   localparam int RQW = SRC_W + TXN_W;

   logic             ar;
   logic [SRC_W-1:0] s0_srcid;
   logic [TXN_W-1:0] s0_txnid;

   logic [CW-1:0]    avail_q, avail_nxt;
   logic [CW-1:0]    resv_q, resv_nxt;
   logic [CW:0]      avail_sum;
   logic             resv_nz;
   logic             err_q;

   logic [RQW-1:0]   rq_mem [RETRYQ_DEPTH];
   logic [RAW-1:0]   rq_wr, rq_rd;
   logic [RCW-1:0]   rq_cnt;
   logic [SRC_W-1:0] pq_mem [PCRDQ_DEPTH];
   logic [PAW-1:0]   pq_wr, pq_rd;
   logic [PCW-1:0]   pq_cnt;

   logic rq_empty, rq_full, pq_empty, pq_full;
   logic retry_cond, retry, acc_ar0, acc_ar1, acc;
   logic ack_xfer, gnt_xfer, rq_push;
   logic [CW-1:0] gnt_thr;

   assign ar       = rxreqflit_s0[AR_BIT];
   assign s0_srcid = rxreqflit_s0[SRCID_LSB +: SRC_W];
   assign s0_txnid = rxreqflit_s0[TXNID_LSB +: TXN_W];

   assign rq_empty = (rq_cnt == '0);
   assign rq_full  = (rq_cnt == RCW'(RETRYQ_DEPTH));
   assign pq_empty = (pq_cnt == '0);
   assign pq_full  = (pq_cnt == PCW'(PCRDQ_DEPTH));
   assign resv_nz  = (resv_q != '0);

   // earlier retried requesters keep priority over new ar=1 traffic
   assign retry_cond = (avail_q == '0) | ~rq_empty | ~pq_empty;
   assign retry      = rxreq_valid_s0 & ar & retry_cond;
   assign acc_ar1    = rxreq_valid_s0 & ar & ~retry_cond;
   assign acc_ar0    = rxreq_valid_s0 & ~ar;
   assign acc        = acc_ar0 | acc_ar1;

   assign rxreq_retry_enable_s0 = retry;

   assign qos_retryack_valid = ~rq_empty & ~pq_full;
   assign ack_xfer = qos_retryack_valid & txrsp_retryack_won_s1;

   always_comb begin
      qos_retryack_srcid = '0;
      qos_retryack_txnid = '0;
      if (qos_retryack_valid) begin
         {qos_retryack_srcid, qos_retryack_txnid} = rq_mem[rq_rd];
      end
   end

   // keep one entry back for a same-cycle ar=1 accept
   assign gnt_thr           = acc_ar1 ? CW'(1) : '0;
   assign qos_pcrdgnt_valid = ~pq_empty & (avail_q > gnt_thr);
   assign qos_pcrdgnt_srcid = qos_pcrdgnt_valid ? pq_mem[pq_rd] : '0;
   assign gnt_xfer = qos_pcrdgnt_valid & txrsp_pcrdgnt_won_s1;

   assign rq_push = retry & (~rq_full | ack_xfer);

   always_comb begin
      avail_sum = {1'b0, avail_q} + (CW+1)'(trk_free_s0);
      if (avail_sum > (CW+1)'(TRK_ENTRIES)) begin
         avail_sum = (CW+1)'(TRK_ENTRIES);
      end
      avail_nxt = CW'(avail_sum) - CW'(acc_ar1) - CW'(gnt_xfer);
      resv_nxt  = resv_q + CW'(gnt_xfer) - CW'(acc_ar0 & resv_nz);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         avail_q <= CW'(TRK_ENTRIES);
         resv_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         avail_q <= avail_nxt;
         resv_q  <= resv_nxt;
         if (acc_ar0 & ~resv_nz) err_q <= 1'b1;
      end
   end

   assign qos_pcrd_err = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         qos_req_valid_s1 <= 1'b0;
         qos_reqflit_s1   <= '0;
      end else begin
         qos_req_valid_s1 <= acc;
         qos_reqflit_s1   <= acc ? rxreqflit_s0 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rq_push) rq_mem[rq_wr] <= {s0_srcid, s0_txnid};
      if (ack_xfer) pq_mem[pq_wr] <= rq_mem[rq_rd][RQW-1 -: SRC_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rq_wr  <= '0;
         rq_rd  <= '0;
         rq_cnt <= '0;
         pq_wr  <= '0;
         pq_rd  <= '0;
         pq_cnt <= '0;
      end else begin
         if (rq_push) begin
            rq_wr <= (rq_wr == RAW'(RETRYQ_DEPTH-1)) ? '0 : rq_wr + RAW'(1);
         end
         if (ack_xfer) begin
            rq_rd <= (rq_rd == RAW'(RETRYQ_DEPTH-1)) ? '0 : rq_rd + RAW'(1);
            pq_wr <= (pq_wr == PAW'(PCRDQ_DEPTH-1)) ? '0 : pq_wr + PAW'(1);
         end
         if (gnt_xfer) begin
            pq_rd <= (pq_rd == PAW'(PCRDQ_DEPTH-1)) ? '0 : pq_rd + PAW'(1);
         end
         rq_cnt <= rq_cnt + RCW'(rq_push) - RCW'(ack_xfer);
         pq_cnt <= pq_cnt + PCW'(ack_xfer) - PCW'(gnt_xfer);
      end
   end

   a_depth: assert property (@(posedge clk)
      RETRYQ_DEPTH >= LL_CRD_COUNT);
   a_rq_ovf: assert property (@(posedge clk) disable iff (rst)
      !(retry && rq_full && !ack_xfer));
   a_free_ovf: assert property (@(posedge clk) disable iff (rst)
      !(trk_free_s0 && avail_q == CW'(TRK_ENTRIES)));

endmodule

// File: tb/tb_hni_req_admit.sv
// Bench for hni_req_admit: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_hni_req_admit;

   localparam int TRK = 16;
   localparam int RQD = 8;
   localparam int PQD = 16;
   localparam int SLSB = 15;
   localparam int TLSB = 26;
   localparam int ARB = 56;

   logic        clk = 0;
   logic        rst;
   logic        rxreq_valid_s0;
   logic [63:0] rxreqflit_s0;
   logic        rxreq_retry_enable_s0;
   logic        trk_free_s0;
   logic        qos_req_valid_s1;
   logic [63:0] qos_reqflit_s1;
   logic        qos_retryack_valid;
   logic [10:0] qos_retryack_srcid;
   logic [11:0] qos_retryack_txnid;
   logic        txrsp_retryack_won_s1;
   logic        qos_pcrdgnt_valid;
   logic [10:0] qos_pcrdgnt_srcid;
   logic        txrsp_pcrdgnt_won_s1;
   logic        qos_pcrd_err;

   hni_req_admit #(
      .TRK_ENTRIES(TRK), .RETRYQ_DEPTH(RQD), .PCRDQ_DEPTH(PQD),
      .LL_CRD_COUNT(8), .REQ_W(64), .SRC_W(11), .TXN_W(12),
      .SRCID_LSB(SLSB), .TXNID_LSB(TLSB), .AR_BIT(ARB)
   ) dut (
      .clk(clk), .rst(rst),
      .rxreq_valid_s0(rxreq_valid_s0),
      .rxreqflit_s0(rxreqflit_s0),
      .rxreq_retry_enable_s0(rxreq_retry_enable_s0),
      .trk_free_s0(trk_free_s0),
      .qos_req_valid_s1(qos_req_valid_s1),
      .qos_reqflit_s1(qos_reqflit_s1),
      .qos_retryack_valid(qos_retryack_valid),
      .qos_retryack_srcid(qos_retryack_srcid),
      .qos_retryack_txnid(qos_retryack_txnid),
      .txrsp_retryack_won_s1(txrsp_retryack_won_s1),
      .qos_pcrdgnt_valid(qos_pcrdgnt_valid),
      .qos_pcrdgnt_srcid(qos_pcrdgnt_srcid),
      .txrsp_pcrdgnt_won_s1(txrsp_pcrdgnt_won_s1),
      .qos_pcrd_err(qos_pcrd_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_avail, m_resv;
   bit          m_err;
   logic [22:0] m_rq[$];
   logic [10:0] m_pq[$];
   bit          m_s1_v;
   logic [63:0] m_s1_f;

   typedef struct {
      logic v, ar;
      logic [10:0] src;
      logic [11:0] txn;
      logic fr, aw, gw;
      logic e_rt, e_s1, e_ack, e_gnt, e_err;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(int v, int ar, int src, int txn,
                               int fr, int aw, int gw, int rt,
                               int s1, int ack, int gnt, int err);
      vec_t r;
      r.v = v[0]; r.ar = ar[0];
      r.src = src[10:0]; r.txn = txn[11:0];
      r.fr = fr[0]; r.aw = aw[0]; r.gw = gw[0];
      r.e_rt = rt[0]; r.e_s1 = s1[0]; r.e_ack = ack[0];
      r.e_gnt = gnt[0]; r.e_err = err[0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic ar,
                        input logic [10:0] src, input logic [11:0] txn,
                        input logic fr, input logic aw, input logic gw);
      logic [63:0] f;
      f = {$urandom, $urandom};
      f[SLSB +: 11] = src;
      f[TLSB +: 12] = txn;
      f[ARB] = ar;
      rst = r;
      rxreq_valid_s0 = v;
      rxreqflit_s0 = f;
      trk_free_s0 = fr;
      txrsp_retryack_won_s1 = aw;
      txrsp_pcrdgnt_won_s1 = gw;
   endtask

   task automatic model_clear();
      m_avail = TRK;
      m_resv = 0;
      m_err = 0;
      m_rq.delete();
      m_pq.delete();
      m_s1_v = 0;
      m_s1_f = '0;
   endtask

   // compare this cycle against the model, then advance one clock
   task automatic mcheck();
      bit a1, a0, rt, av, gv, ax, gx;
      logic [22:0] hd;
      logic [22:0] eid;
      logic [10:0] egs;
      logic [10:0] src;
      logic [11:0] txn;
      logic ar;
      ar = rxreqflit_s0[ARB];
      src = rxreqflit_s0[SLSB +: 11];
      txn = rxreqflit_s0[TLSB +: 12];
      a1 = rxreq_valid_s0 && ar && m_avail > 0 &&
           m_rq.size() == 0 && m_pq.size() == 0;
      a0 = rxreq_valid_s0 && !ar;
      rt = rxreq_valid_s0 && ar && !a1;
      av = m_rq.size() > 0 && m_pq.size() < PQD;
      gv = m_pq.size() > 0 && m_avail > (a1 ? 1 : 0);
      ax = av && txrsp_retryack_won_s1;
      gx = gv && txrsp_pcrdgnt_won_s1;
      eid = '0;
      egs = '0;
      if (av) eid = m_rq[0];
      if (gv) egs = m_pq[0];
      if (!rst) begin
         chk("retry_en", rxreq_retry_enable_s0, rt);
         chk("s1_valid", qos_req_valid_s1, m_s1_v);
         chk("s1_flit", qos_reqflit_s1, m_s1_f);
         chk("ack_valid", qos_retryack_valid, av);
         chk("ack_id", {qos_retryack_srcid, qos_retryack_txnid}, eid);
         chk("gnt_valid", qos_pcrdgnt_valid, gv);
         chk("gnt_src", qos_pcrdgnt_srcid, egs);
         chk("pcrd_err", qos_pcrd_err, m_err);
      end
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (gx) void'(m_pq.pop_front());
         if (ax) begin
            hd = m_rq.pop_front();
            m_pq.push_back(hd[22:12]);
         end
         if (rt && m_rq.size() < RQD) m_rq.push_back({src, txn});
         m_avail = m_avail + int'(trk_free_s0);
         if (m_avail > TRK) m_avail = TRK;
         m_avail = m_avail - int'(a1) - int'(gx);
         if (a0) begin
            if (m_resv > 0) m_resv--;
            else m_err = 1;
         end
         if (gx) m_resv++;
         m_s1_v = a1 || a0;
         m_s1_f = m_s1_v ? rxreqflit_s0 : '0;
      end
      @(negedge clk);
   endtask

   task automatic idle_chk_zero(input string nm);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk({nm, "_rt"}, rxreq_retry_enable_s0, 0);
      chk({nm, "_s1v"}, qos_req_valid_s1, 0);
      chk({nm, "_s1f"}, qos_reqflit_s1, 0);
      chk({nm, "_ack"}, qos_retryack_valid, 0);
      chk({nm, "_gnt"}, qos_pcrdgnt_valid, 0);
      chk({nm, "_err"}, qos_pcrd_err, 0);
      mcheck();
   endtask

   task automatic fill16(input string nm);
      for (int i = 0; i < TRK; i++) begin
         drive(0, 1, 1, 11'(i + 1), 12'(i + 'h100), 0, 0, 0);
         #1;
         chk({nm, "_acc_rt"}, rxreq_retry_enable_s0, 0);
         mcheck();
      end
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 1, 1, 11'(i), 12'(i), 0, 1, 1);
         #1;
         mcheck();
      end
   endtask

   initial begin
      bit v, ar, fr;
      tbl[0]  = mk(0, 0, 0, 0,   0, 1, 0,  0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,   0, 0, 1,  0, 0, 0, 1, 0);
      tbl[3]  = mk(1, 0, 7, 3,   0, 0, 0,  0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 0, 8, 4,   0, 0, 0,  0, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0,   0, 0, 0,  0, 1, 0, 0, 1);
      tbl[6]  = mk(1, 1, 9, 9,   0, 0, 0,  1, 0, 0, 0, 1);
      tbl[7]  = mk(0, 0, 0, 0,   0, 1, 0,  0, 0, 1, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0, 1);
      tbl[9]  = mk(1, 1, 10, 10, 0, 0, 1,  1, 0, 0, 1, 1);
      tbl[10] = mk(0, 0, 0, 0,   0, 1, 0,  0, 0, 1, 0, 1);
      tbl[11] = mk(0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0, 1);
      tbl[12] = mk(0, 0, 0, 0,   1, 0, 0,  0, 0, 0, 1, 1);
      tbl[13] = mk(1, 0, 11, 11, 1, 0, 1,  0, 0, 0, 1, 1);
      tbl[14] = mk(1, 1, 12, 12, 0, 0, 0,  0, 1, 0, 0, 1);
      tbl[15] = mk(0, 0, 0, 0,   0, 0, 0,  0, 1, 0, 0, 1);

      model_clear();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_cycles(2);
      idle_chk_zero("reset");

      // full tracker, then one retried requester
      fill16("t1");
      drive(0, 1, 1, 11'd5, 12'h2A, 0, 0, 0);
      #1;
      chk("t1_17th_rt", rxreq_retry_enable_s0, 1);
      mcheck();
      chk("t1_ack_src", qos_retryack_srcid, 5);
      chk("t1_ack_txn", qos_retryack_txnid, 'h2A);

      // grant/credit/err sequence and simultaneous counter events
      for (int i = 0; i < 16; i++) begin
         drive(0, tbl[i].v, tbl[i].ar, tbl[i].src, tbl[i].txn,
               tbl[i].fr, tbl[i].aw, tbl[i].gw);
         #1;
         chk($sformatf("tbl%0d_rt", i), rxreq_retry_enable_s0, tbl[i].e_rt);
         chk($sformatf("tbl%0d_s1", i), qos_req_valid_s1, tbl[i].e_s1);
         chk($sformatf("tbl%0d_ack", i), qos_retryack_valid, tbl[i].e_ack);
         chk($sformatf("tbl%0d_gnt", i), qos_pcrdgnt_valid, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_err", i), qos_pcrd_err, tbl[i].e_err);
         if (tbl[i].e_gnt) begin
            chk($sformatf("tbl%0d_gsrc", i), qos_pcrdgnt_srcid,
                i == 2 ? 5 : (i == 9 ? 9 : 10));
         end
         mcheck();
      end

      // PCrdGrant FIFO full blocks RetryAck; retry FIFO fills to depth
      reset_cycles(1);
      fill16("t6");
      for (int i = 0; i < PQD + RQD; i++) begin
         drive(0, 1, 1, 11'(i + 'h40), 12'(i), 0, 1, 0);
         #1;
         mcheck();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      chk("t6_ack_blocked", qos_retryack_valid, 0);
      chk("t6_gnt_noavail", qos_pcrdgnt_valid, 0);
      mcheck();
      reset_cycles(1);
      idle_chk_zero("t6_rst");
      fill16("t6b");
      drive(0, 1, 1, 11'd3, 12'd3, 0, 0, 0);
      #1;
      chk("t6_avail16_rt", rxreq_retry_enable_s0, 1);
      mcheck();

      // randomized traffic
      reset_cycles(1);
      for (int n = 0; n < 3000; n++) begin
         v = ($urandom_range(0, 3) != 0);
         ar = ($urandom_range(0, 3) != 0);
         if (m_rq.size() >= RQD) ar = 0;
         if (!ar && m_resv == 0 && $urandom_range(0, 7) != 0) v = 0;
         fr = (m_avail + m_resv < TRK) && ($urandom_range(0, 2) == 0);
         drive(0, v, ar, 11'($urandom), 12'($urandom), fr,
               1'($urandom), 1'($urandom));
         #1;
         mcheck();
         if (n == 1500) reset_cycles(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
